divider_req_sequencer: RTL

- Upstream feeder and result collector for the 32-bit shift/subtract divider.
- Accepts operand pairs from a producer through a valid/ready push interface and buffers them in a small FIFO.
- Issues each pair to the divider using the divider's level start_sig / one-cycle dong_sig handshake.
- Presents each quotient/remainder on a registered result port with a one-cycle done pulse.

---
 rtl/divider_pkg.sv | 15 +
 rtl/div_req_fifo.sv | 74 +++++++
 rtl/divider_req_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the divider request sequencer.
package divider_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } seq_state_t;

  // Quotient reported for a zero divisor when the bypass is enabled.
  localparam logic [DIV_DATA_W-1:0] DIV_QUOT_ONES = '1;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divider sequencer: DEPTH entries of {dividend, divisor}.
// The head entry is always visible on rdata; full is registered from the next level.
module div_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   rdata,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] level
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic [PTR_W:0]   level_next;
  logic             full_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_reg;
  assign do_pop  = pop && (level_reg != '0);

  always_comb begin
    level_next = level_reg;
    if (do_push && !do_pop) begin
      level_next = level_reg + LVL_ONE;
    end else if (!do_push && do_pop) begin
      level_next = level_reg - LVL_ONE;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      level_reg <= level_next;
      full_reg  <= (level_next == LVL_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = (level_reg == '0);
  assign level = level_reg;

endmodule

// File: rtl/divider_req_sequencer.sv
// Queues operand pairs, issues them to the shift/subtract divider and registers results.
// Optional zero-divisor bypass: define DIVIDER_REQ_DIVZERO_BYPASS_EN.
module divider_req_sequencer
  import divider_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_sig,
  input  logic [DATA_W-1:0] req_dividend,
  input  logic [DATA_W-1:0] req_divisor,
  output logic              req_ready,
  output logic              div_start_sig,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic              div_dong_sig,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_reminder,
  output logic              res_dong_sig,
  output logic [DATA_W-1:0] res_quotient,
  output logic [DATA_W-1:0] res_reminder,
  output logic              res_err,
  output logic [PTR_W:0]    fifo_level
);

  seq_state_t          state_reg;
  logic [2*DATA_W-1:0] head;
  logic [DATA_W-1:0]   head_dividend;
  logic [DATA_W-1:0]   head_divisor;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;

  assign {head_dividend, head_divisor} = head;
  assign pop       = (state_reg == IDLE) && !fifo_empty;
  assign req_ready = !fifo_full;

  div_req_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * DATA_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_sig),
    .pop   (pop),
    .wdata ({req_dividend, req_divisor}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef DIVIDER_REQ_DIVZERO_BYPASS_EN
  logic err_reg;
  assign res_err = err_reg;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      div_start_sig <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      res_dong_sig  <= 1'b0;
      res_quotient  <= '0;
      res_reminder  <= '0;
`ifdef DIVIDER_REQ_DIVZERO_BYPASS_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      res_dong_sig <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (pop) begin
`ifdef DIVIDER_REQ_DIVZERO_BYPASS_EN
            // A zero divisor is answered locally and never reaches the divider.
            if (head_divisor == '0) begin
              res_quotient <= DIV_QUOT_ONES;
              res_reminder <= head_dividend;
              err_reg      <= 1'b1;
              res_dong_sig <= 1'b1;
              state_reg    <= RELEASE;
            end else
`endif
            begin
              div_dividend  <= head_dividend;
              div_divisor   <= head_divisor;
              div_start_sig <= 1'b1;
              state_reg     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (div_dong_sig) begin
            res_quotient  <= div_quotient;
            res_reminder  <= div_reminder;
            res_dong_sig  <= 1'b1;
            div_start_sig <= 1'b0;
`ifdef DIVIDER_REQ_DIVZERO_BYPASS_EN
            err_reg       <= 1'b0;
`endif
            state_reg     <= RELEASE;
          end
        end
        // One cycle with start low lets the divider return to its idle state.
        RELEASE: begin
          div_start_sig <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          div_start_sig <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule
